// File: rtl/rggen_bus_arbiter_if.sv
// Register-bus interface shared by the bus bridges, the arbiter and the register-block adapter.
// access: 2'b10 read, 2'b11 write, 2'b01 posted write; status: 00 OKAY, 01 EXOKAY, 10 SLAVE_ERROR, 11 DECODE_ERROR.
interface rggen_bus_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    logic                     valid;
    logic [1:0]               access;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH/8-1:0]   strobe;
    logic                     ready;
    logic [1:0]               status;
    logic [BUS_WIDTH-1:0]     read_data;

    modport master (
        output valid, access, address, write_data, strobe,
        input  ready, status, read_data
    );

    modport slave (
        input  valid, access, address, write_data, strobe,
        output ready, status, read_data
    );
endinterface

// File: rtl/rggen_bus_arbiter.sv
// Shares one rggen_bus_if target between HOSTS requesters; per-transaction round-robin
// or fixed-priority arbitration with zero added latency and grant held until ready.
module rggen_bus_arbiter #(
    parameter int HOSTS          = 2,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    rggen_bus_if.slave       host_if [HOSTS],
    rggen_bus_if.master      bus_if,
    output logic [HOSTS-1:0] o_grant
);
    localparam int          IDX_W       = (HOSTS > 1) ? $clog2(HOSTS) : 1;
    localparam int          STRB_W      = BUS_WIDTH / 8;
    localparam int unsigned NH          = HOSTS;
    localparam logic [1:0]  STATUS_OKAY = 2'b00;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e           state_q, state_d;
    logic [HOSTS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [HOSTS-1:0]         req;
    logic [1:0]               access_a  [HOSTS];
    logic [ADDRESS_WIDTH-1:0] address_a [HOSTS];
    logic [BUS_WIDTH-1:0]     wdata_a   [HOSTS];
    logic [STRB_W-1:0]        strobe_a  [HOSTS];

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [HOSTS-1:0] cur_grant;
    logic [IDX_W-1:0] cur_idx;

    function automatic logic [HOSTS-1:0] onehot(input logic [IDX_W-1:0] k);
        logic [HOSTS-1:0] f;
        f = '0;
        for (int unsigned i = 0; i < NH; i++) begin
            f[i] = (k == IDX_W'(i));
        end
        return f;
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] k);
        if (k == IDX_W'(NH - 1)) begin
            return '0;
        end
        return k + IDX_W'(1);
    endfunction

    for (genvar i = 0; i < HOSTS; i++) begin : g_host
        assign req[i]       = host_if[i].valid;
        assign access_a[i]  = host_if[i].access;
        assign address_a[i] = host_if[i].address;
        assign wdata_a[i]   = host_if[i].write_data;
        assign strobe_a[i]  = host_if[i].strobe;

        assign host_if[i].ready     = cur_grant[i] & bus_if.ready;
        assign host_if[i].status    = cur_grant[i] ? bus_if.status : STATUS_OKAY;
        assign host_if[i].read_data = cur_grant[i] ? bus_if.read_data : '0;
    end

    // Search upward from the base index, wrapping; fixed priority always starts at host 0.
    always_comb begin
        int unsigned idx;
        int unsigned base;
        win_found = 1'b0;
        win_idx   = '0;
        base      = (FIXED_PRIORITY != 0) ? 0 : int'(ptr_q);
        for (int unsigned k = 0; k < NH; k++) begin
            idx = base + k;
            if (idx >= NH) begin
                idx = idx - NH;
            end
            if (!win_found && req[IDX_W'(idx)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cur_grant = '0;
        cur_idx   = owner_q;
        // Outputs are forced idle while reset is held so an abort is visible immediately.
        if (i_rst_n) begin
            unique case (state_q)
                IDLE: begin
                    if (win_found) begin
                        cur_idx   = win_idx;
                        cur_grant = onehot(win_idx);
                        if (bus_if.ready) begin
                            ptr_d = next_ptr(win_idx);
                        end else begin
                            state_d = BUSY;
                            grant_d = onehot(win_idx);
                            owner_d = win_idx;
                        end
                    end
                end
                BUSY: begin
                    cur_grant = grant_q;
                    if (bus_if.ready) begin
                        state_d = IDLE;
                        grant_d = '0;
                        ptr_d   = next_ptr(owner_q);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_grant           = cur_grant;
    assign bus_if.valid      = |(cur_grant & req);
    assign bus_if.access     = access_a[cur_idx];
    assign bus_if.address    = address_a[cur_idx];
    assign bus_if.write_data = wdata_a[cur_idx];
    assign bus_if.strobe     = strobe_a[cur_idx];

`ifdef RGGEN_ENABLE_SVA
    a_grant_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_grant));
    a_busy_grant_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (state_q == BUSY && !bus_if.ready) |=> (o_grant == $past(o_grant)));
    a_valid_has_grant: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        bus_if.valid |-> (o_grant != '0));
`endif
endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Randomized scoreboard bench: a round-robin and a fixed-priority arbiter (2 hosts each)
// driven by independent random hosts/downstream, checked against a transaction-level model.
module tb_rggen_bus_arbiter;
    localparam int HOSTS = 2;
    localparam int AW    = 8;
    localparam int BW    = 32;
    localparam int SW    = BW / 8;
    localparam int NDUT  = 2;
    localparam logic [1:0] OKAY        = 2'b00;
    localparam logic [1:0] SLAVE_ERROR = 2'b10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          h_valid  [NDUT][HOSTS];
    logic [1:0]    h_access [NDUT][HOSTS];
    logic [AW-1:0] h_addr   [NDUT][HOSTS];
    logic [BW-1:0] h_wdata  [NDUT][HOSTS];
    logic [SW-1:0] h_strb   [NDUT][HOSTS];
    logic          h_ready  [NDUT][HOSTS];
    logic [1:0]    h_status [NDUT][HOSTS];
    logic [BW-1:0] h_rdata  [NDUT][HOSTS];

    logic          d_ready  [NDUT];
    logic [1:0]    d_status [NDUT];
    logic [BW-1:0] d_rdata  [NDUT];
    logic          b_valid  [NDUT];
    logic [1:0]    b_access [NDUT];
    logic [AW-1:0] b_addr   [NDUT];
    logic [BW-1:0] b_wdata  [NDUT];
    logic [SW-1:0] b_strb   [NDUT];
    logic [HOSTS-1:0] grant [NDUT];

    for (genvar d = 0; d < NDUT; d++) begin : g_dut
        rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) hif [HOSTS] ();
        rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) dif ();

        for (genvar h = 0; h < HOSTS; h++) begin : g_h
            assign hif[h].valid      = h_valid[d][h];
            assign hif[h].access     = h_access[d][h];
            assign hif[h].address    = h_addr[d][h];
            assign hif[h].write_data = h_wdata[d][h];
            assign hif[h].strobe     = h_strb[d][h];
            assign h_ready[d][h]     = hif[h].ready;
            assign h_status[d][h]    = hif[h].status;
            assign h_rdata[d][h]     = hif[h].read_data;
        end

        assign dif.ready     = d_ready[d];
        assign dif.status    = d_status[d];
        assign dif.read_data = d_rdata[d];
        assign b_valid[d]    = dif.valid;
        assign b_access[d]   = dif.access;
        assign b_addr[d]     = dif.address;
        assign b_wdata[d]    = dif.write_data;
        assign b_strb[d]     = dif.strobe;

        rggen_bus_arbiter #(
            .HOSTS          (HOSTS),
            .ADDRESS_WIDTH  (AW),
            .BUS_WIDTH      (BW),
            .FIXED_PRIORITY (d)
        ) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .host_if (hif),
            .bus_if  (dif),
            .o_grant (grant[d])
        );
    end

    typedef struct {
        int            host;
        logic [1:0]    acc;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        logic [SW-1:0] strb;
    } exp_t;

    exp_t             sbq [NDUT][$];
    exp_t             mon_e;
    int               owner     [NDUT];
    int               ptr       [NDUT];
    int               done_host [NDUT];
    logic [HOSTS-1:0] exp_grant [NDUT];
    int unsigned      req_pct;
    int unsigned      rdy_pct;
    bit               gen_en;
    int               checks;
    int               failures;

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, d, $time, act, exp);
        end
    endtask

    task automatic new_req(input int d, input int h);
        h_valid[d][h]  = 1'b1;
        h_access[d][h] = ($urandom_range(1) != 0) ? 2'b11 : 2'b10;
        if ($urandom_range(1) != 0) h_addr[d][h] = (h == 0) ? 8'h20 : 8'h24;
        else                        h_addr[d][h] = AW'($urandom);
        h_wdata[d][h] = $urandom;
        h_strb[d][h]  = SW'($urandom);
    endtask

    function automatic bit all_idle();
        for (int d = 0; d < NDUT; d++) begin
            if (owner[d] >= 0 || done_host[d] >= 0) return 1'b0;
            for (int h = 0; h < HOSTS; h++) if (h_valid[d][h]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One cycle of hosts, downstream and reference model; called just after a rising edge.
    task automatic step();
        exp_t e;
        int   base;
        int   idx;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            if (done_host[d] >= 0) begin
                h_valid[d][done_host[d]] = 1'b0;
                ptr[d] = (done_host[d] + 1) % HOSTS;
                done_host[d] = -1;
            end
            for (int h = 0; h < HOSTS; h++) begin
                if (gen_en && !h_valid[d][h] && $urandom_range(99) < req_pct) new_req(d, h);
            end
            d_ready[d]  = ($urandom_range(99) < rdy_pct);
            d_status[d] = ($urandom_range(1) != 0) ? SLAVE_ERROR : OKAY;
            d_rdata[d]  = $urandom;
            if (owner[d] < 0) begin
                base = (d == 1) ? 0 : ptr[d];
                for (int k = 0; k < HOSTS; k++) begin
                    idx = (base + k) % HOSTS;
                    if (owner[d] < 0 && h_valid[d][idx]) begin
                        owner[d] = idx;
                        e.host  = idx;
                        e.acc   = h_access[d][idx];
                        e.addr  = h_addr[d][idx];
                        e.wdata = h_wdata[d][idx];
                        e.strb  = h_strb[d][idx];
                        sbq[d].push_back(e);
                    end
                end
            end
            exp_grant[d] = (owner[d] >= 0) ? HOSTS'(1) << owner[d] : '0;
            if (owner[d] >= 0 && d_ready[d]) begin
                done_host[d] = owner[d];
                owner[d] = -1;
            end
        end
        @(posedge clk);
    endtask

    task automatic drain();
        gen_en = 1'b0;
        for (int n = 0; n < 400 && !all_idle(); n++) step();
        checks++;
        if (!all_idle()) begin
            failures++;
            $display("FAIL drain_timeout t=%0t: got busy expected idle", $time);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            chk("grant", d, 64'(grant[d]), 64'(exp_grant[d]));
            chk("bus_valid", d, 64'(b_valid[d]), 64'(exp_grant[d] != '0));
            for (int h = 0; h < HOSTS; h++) begin
                chk($sformatf("host%0d_ready", h), d, 64'(h_ready[d][h]), 64'(exp_grant[d][h] & d_ready[d]));
                chk($sformatf("host%0d_status", h), d, 64'(h_status[d][h]), 64'(exp_grant[d][h] ? d_status[d] : OKAY));
                chk($sformatf("host%0d_rdata", h), d, 64'(h_rdata[d][h]), 64'(exp_grant[d][h] ? d_rdata[d] : '0));
            end
            if (b_valid[d] && d_ready[d]) begin
                if (sbq[d].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_txn dut%0d t=%0t: got completion expected none", d, $time);
                end else begin
                    mon_e = sbq[d].pop_front();
                    chk("txn_host", d, 64'(grant[d]), 64'(HOSTS'(1) << mon_e.host));
                    chk("txn_access", d, 64'(b_access[d]), 64'(mon_e.acc));
                    chk("txn_addr", d, 64'(b_addr[d]), 64'(mon_e.addr));
                    chk("txn_wdata", d, 64'(b_wdata[d]), 64'(mon_e.wdata));
                    chk("txn_strobe", d, 64'(b_strb[d]), 64'(mon_e.strb));
                end
            end
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        gen_en = 1'b0;
        req_pct = 0;
        rdy_pct = 0;
        for (int d = 0; d < NDUT; d++) begin
            owner[d] = -1;
            ptr[d] = 0;
            done_host[d] = -1;
            exp_grant[d] = '0;
            d_ready[d] = 1'b0;
            d_status[d] = OKAY;
            d_rdata[d] = '0;
            for (int h = 0; h < HOSTS; h++) begin
                h_valid[d][h] = 1'b0;
                h_access[d][h] = 2'b10;
                h_addr[d][h] = '0;
                h_wdata[d][h] = '0;
                h_strb[d][h] = '0;
            end
        end

        // Both hosts request while reset is held: nothing may be granted until release.
        repeat (2) @(posedge clk);
        #2;
        for (int d = 0; d < NDUT; d++) begin
            new_req(d, 0);
            new_req(d, 1);
        end
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk("rst_grant", d, 64'(grant[d]), 64'(0));
            chk("rst_bus_valid", d, 64'(b_valid[d]), 64'(0));
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        rdy_pct = 30;
        repeat (12) step();

        gen_en = 1'b1;
        req_pct = 50;  rdy_pct = 40;  repeat (400) step();
        req_pct = 100; rdy_pct = 35;  repeat (300) step();
        req_pct = 25;  rdy_pct = 70;  repeat (300) step();
        rdy_pct = 50;
        drain();

        // Abort host1 mid-transaction, then both hosts request at release.
        rdy_pct = 0;
        for (int d = 0; d < NDUT; d++) new_req(d, 1);
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk("abort_grant", d, 64'(grant[d]), 64'(0));
            chk("abort_bus_valid", d, 64'(b_valid[d]), 64'(0));
            owner[d] = -1;
            done_host[d] = -1;
            ptr[d] = 0;
            exp_grant[d] = '0;
            sbq[d].delete();
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int d = 0; d < NDUT; d++) new_req(d, 0);
        rdy_pct = 50;
        step();
        drain();

        for (int d = 0; d < NDUT; d++) chk("sb_empty", d, 64'(sbq[d].size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
